fft_output_reorder: RTL and testbench

- Sits directly downstream of the mixed-radix FFT top level.
- Captures FFT output samples, which arrive in scrambled order with a per-sample `address`, into a ping-pong buffer.
- Once a frame is complete, replays it in natural bin order 0..points-1 as a continuous stream for the PUSCH demapping stages.
- One bank is written while the other drains, so back-to-back frames need no stall.

---
 rtl/fft_output_reorder.sv | 219 +++++++++++++++++++++
 tb/tb_fft_output_reorder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
// rtl/fft_output_reorder.sv - ping-pong buffer that replays scrambled FFT output in natural bin order
module fft_output_reorder #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    points,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic [AW-1:0]    wr_addr,
  input  logic             di_last,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [AW-1:0]    do_index,
  output logic             do_last,
  output logic             overflow,
  output logic             addr_err
);

  localparam logic [1:0] B_EMPTY    = 2'd0;
  localparam logic [1:0] B_FILLING  = 2'd1;
  localparam logic [1:0] B_FULL     = 2'd2;
  localparam logic [1:0] B_DRAINING = 2'd3;

  // points is only AW bits wide, so a full-depth frame (DEPTH == 2^AW) arrives as 0
  localparam logic [AW:0] PTS_MAX = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_READ} rd_state_t;

  rd_state_t            state_q, state_d;
  logic [1:0][1:0]      bst_q, bst_d;
  logic [1:0][AW:0]     pts_q, pts_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic [AW:0]          rc_q, rc_d;
  logic                 overflow_q, overflow_d;
  logic                 addr_err_q, addr_err_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [AW-1:0]        rd_idx_q, rd_idx_d;
  logic                 rd_last_q, rd_last_d;
  logic                 do_en_q, do_en_d;
  logic [WIDTH-1:0]     do_re_q, do_re_d;
  logic [WIDTH-1:0]     do_im_q, do_im_d;
  logic [AW-1:0]        do_index_q, do_index_d;
  logic                 do_last_q, do_last_d;

  logic [2*WIDTH-1:0]   mem0 [0:DEPTH-1];
  logic [2*WIDTH-1:0]   mem1 [0:DEPTH-1];
  logic [2*WIDTH-1:0]   rd_data_q;

  logic                 cur_full, nxt_full, rd_at_end;
  logic                 rd_issue, rd_claim, rd_release, rd_chain;
  logic [1:0]           wst;
  logic                 w_open, w_in_range, mem_we;
  logic [AW:0]          pts_in, w_pts;
  logic [AW-1:0]        rd_addr;

  assign cur_full  = (bst_q[rbank_q] == B_FULL);
  assign nxt_full  = (bst_q[~rbank_q] == B_FULL);
  assign rd_at_end = (rc_q == pts_q[rbank_q] - (AW+1)'(1));
  assign rd_addr   = rc_q[AW-1:0];

  assign pts_in     = (points == '0) ? PTS_MAX : {1'b0, points};
  assign wst        = bst_q[wbank_q];
  assign w_open     = (wst == B_EMPTY) || (wst == B_FILLING);
  assign w_pts      = (wst == B_EMPTY) ? pts_in : pts_q[wbank_q];
  assign w_in_range = ({1'b0, wr_addr} < w_pts);
  assign mem_we     = di_en && w_open && w_in_range;

  // Read FSM next state: chain straight into the other bank when it is already full
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = cur_full ? S_READ : S_IDLE;
      S_READ:  state_d = rd_at_end ? (nxt_full ? S_READ : S_IDLE) : S_READ;
      default: state_d = S_IDLE;
    endcase
  end

  // Read FSM outputs: issue reads, claim a full bank, release the drained bank
  always_comb begin
    rd_issue   = 1'b0;
    rd_claim   = 1'b0;
    rd_release = 1'b0;
    rd_chain   = 1'b0;
    case (state_q)
      S_IDLE: rd_claim = cur_full;
      S_READ: begin
        rd_issue   = 1'b1;
        rd_release = rd_at_end;
        rd_chain   = rd_at_end && nxt_full;
      end
      default: ;
    endcase
  end

  // Bank bookkeeping: read side only touches FULL/DRAINING banks, write side only EMPTY/FILLING
  always_comb begin
    bst_d      = bst_q;
    pts_d      = pts_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    rc_d       = rc_q;
    overflow_d = overflow_q;
    addr_err_d = addr_err_q;

    if (rd_claim) begin
      bst_d[rbank_q] = B_DRAINING;
      rc_d           = '0;
    end else if (rd_issue) begin
      rc_d = rc_q + (AW+1)'(1);
    end
    if (rd_release) begin
      bst_d[rbank_q] = B_EMPTY;
      rbank_d        = ~rbank_q;
      if (rd_chain) begin
        bst_d[~rbank_q] = B_DRAINING;
        rc_d            = '0;
      end
    end

    // A bank released this cycle is still seen as DRAINING here, so the write is dropped
    if (di_en) begin
      if (w_open) begin
        if (wst == B_EMPTY) begin
          pts_d[wbank_q] = pts_in;
        end
        bst_d[wbank_q] = B_FILLING;
        if (!w_in_range) begin
          addr_err_d = 1'b1;
        end
        if (di_last) begin
          bst_d[wbank_q] = B_FULL;
          wbank_d        = ~wbank_q;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Output pipeline: RAM read stage, then registered output stage
  always_comb begin
    rd_valid_d = rd_issue;
    rd_idx_d   = rd_addr;
    rd_last_d  = rd_issue && rd_at_end;
    do_en_d    = rd_valid_q;
    do_re_d    = rd_valid_q ? rd_data_q[2*WIDTH-1:WIDTH] : '0;
    do_im_d    = rd_valid_q ? rd_data_q[WIDTH-1:0] : '0;
    do_index_d = rd_valid_q ? rd_idx_q : '0;
    do_last_d  = rd_valid_q && rd_last_q;
  end

  // State and pipeline registers; reset abandons all frames and restarts in bank 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bst_q      <= {B_EMPTY, B_EMPTY};
      pts_q      <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      rc_q       <= '0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
      do_en_q    <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      do_index_q <= '0;
      do_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bst_q      <= bst_d;
      pts_q      <= pts_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      rc_q       <= rc_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_last_q  <= rd_last_d;
      do_en_q    <= do_en_d;
      do_re_q    <= do_re_d;
      do_im_q    <= do_im_d;
      do_index_q <= do_index_d;
      do_last_q  <= do_last_d;
    end
  end

  // Bank RAMs: one synchronous write and one synchronous read per cycle, contents not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (wbank_q) begin
        mem1[wr_addr] <= {di_re, di_im};
      end else begin
        mem0[wr_addr] <= {di_re, di_im};
      end
    end
    if (rd_issue) begin
      rd_data_q <= rbank_q ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

  assign do_en    = do_en_q;
  assign do_re    = do_re_q;
  assign do_im    = do_im_q;
  assign do_index = do_index_q;
  assign do_last  = do_last_q;
  assign overflow = overflow_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// tb/tb_fft_output_reorder.sv - scoreboard bench for fft_output_reorder
module tb_fft_output_reorder;
  localparam int WIDTH = 18;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    points;
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic [AW-1:0]    wr_addr;
  logic             di_last;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [AW-1:0]    do_index;
  logic             do_last;
  logic             overflow;
  logic             addr_err;

  fft_output_reorder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .points(points), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .wr_addr(wr_addr), .di_last(di_last), .do_en(do_en), .do_re(do_re), .do_im(do_im),
    .do_index(do_index), .do_last(do_last), .overflow(overflow), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic [AW-1:0]    idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   run_len  = 0;
  int   last_run = 0;
  int   n_out    = 0;
  logic prev_en   = 1'b0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: pop the scoreboard on every output sample and check framing continuity
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!rst) begin
      run_len   = 0;
      prev_en   = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (do_en) begin
        a.re = do_re; a.im = do_im; a.idx = do_index; a.last = do_last;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got idx=%0d re=%0d, required no output", do_index, do_re);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL out_sample: got re=%0d im=%0d idx=%0d last=%0b, required re=%0d im=%0d idx=%0d last=%0b",
                     a.re, a.im, a.idx, a.last, e.re, e.im, e.idx, e.last);
          end
        end
        run_len++;
        n_out++;
      end else begin
        if (prev_en) begin
          last_run = run_len;
          checks++;
          if (!prev_last) begin
            errors++;
            $display("FAIL gap: do_en dropped without do_last, got last=0, required last=1");
          end
        end
        run_len = 0;
      end
      prev_en   = do_en;
      prev_last = do_last;
    end
  end

  task automatic drive(input int addr, input int re, input int im, input bit last, input int pts);
    @(negedge clk);
    di_en   = 1'b1;
    wr_addr = AW'(addr);
    di_re   = WIDTH'(re);
    di_im   = WIDTH'(im);
    di_last = last;
    points  = AW'(pts);
  endtask

  task automatic idle_in();
    @(negedge clk);
    di_en   = 1'b0;
    di_last = 1'b0;
  endtask

  task automatic push_frame(input int pts, input int tag);
    exp_t e;
    for (int i = 0; i < pts; i++) begin
      e.re = WIDTH'(10 * i); e.im = WIDTH'(tag * 1024 + i);
      e.idx = AW'(i); e.last = (i == pts - 1);
      exp_q.push_back(e);
    end
  endtask

  // Scrambled order (i*7 mod pts) is a permutation for every frame size used here
  task automatic send_frame(input int pts, input int tag, input bit push);
    int a;
    if (push) push_frame(pts, tag);
    for (int i = 0; i < pts; i++) begin
      a = (i * 7) % pts;
      drive(a, 10 * a, tag * 1024 + a, (i == pts - 1), pts);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_addr [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    int base;
    exp_t e;
    rst = 1'b0; points = '0; di_en = 1'b0; di_re = '0; di_im = '0; wr_addr = '0; di_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_do_en", 64'(do_en), 64'd0);
    chk("rst_do_re", 64'(do_re), 64'd0);
    chk("rst_do_im", 64'(do_im), 64'd0);
    chk("rst_do_index", 64'(do_index), 64'd0);
    chk("rst_do_last", 64'(do_last), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_addr_err", 64'(addr_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 12-point frame in scrambled order, with latency check
    push_frame(12, 1);
    for (int i = 0; i < 12; i++) drive(t1_addr[i], 10 * t1_addr[i], 1024 + t1_addr[i], (i == 11), 12);
    @(posedge clk); #1;
    chk("t1_lat_t0", 64'(do_en), 64'd0);
    @(negedge clk); di_en = 1'b0; di_last = 1'b0;
    @(posedge clk); #1;
    chk("t1_lat_t1", 64'(do_en), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat_t2", 64'(do_en), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat_t3", 64'(do_en), 64'd1);
    chk("t1_first_index", 64'(do_index), 64'd0);
    wait_drain("t1_drain", 100);
    chk("t1_run", 64'(last_run), 64'd12);

    // Two back-to-back 60-point frames
    send_frame(60, 2, 1'b1);
    send_frame(60, 3, 1'b1);
    idle_in();
    wait_drain("t2_drain", 300);
    chk("t2_run", 64'(last_run), 64'd120);
    chk("t2_overflow", 64'(overflow), 64'd0);

    // Third frame arrives while both banks are busy and is dropped entirely
    send_frame(300, 4, 1'b1);
    send_frame(60, 5, 1'b1);
    send_frame(60, 6, 1'b0);
    idle_in();
    wait_drain("t3_drain", 1000);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_run", 64'(last_run), 64'd360);
    chk("t3_addr_err", 64'(addr_err), 64'd0);

    // Out-of-range address in a 12-point frame
    base = n_out;
    push_frame(12, 7);
    for (int i = 0; i < 12; i++) begin
      drive((i * 7) % 12, 10 * ((i * 7) % 12), 7 * 1024 + (i * 7) % 12, (i == 11), 12);
      if (i == 5) drive(15, 999, 999, 1'b0, 12);
    end
    idle_in();
    wait_drain("t4_drain", 100);
    chk("t4_addr_err", 64'(addr_err), 64'd1);
    chk("t4_count", 64'(n_out - base), 64'd12);

    // Single-point frame
    base = n_out;
    e.re = WIDTH'(7); e.im = WIDTH'(8 * 1024); e.idx = '0; e.last = 1'b1;
    exp_q.push_back(e);
    drive(0, 7, 8 * 1024, 1'b1, 1);
    idle_in();
    wait_drain("t5_drain", 50);
    chk("t5_count", 64'(n_out - base), 64'd1);
    chk("t5_run", 64'(last_run), 64'd1);

    // Reset in the middle of draining a 48-point frame
    send_frame(48, 9, 1'b1);
    idle_in();
    for (int k = 0; k < 30 && !do_en; k++) @(negedge clk);
    chk("t6_started", 64'(do_en), 64'd1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_do_en", 64'(do_en), 64'd0);
    chk("t6_async_overflow", 64'(overflow), 64'd0);
    chk("t6_async_addr_err", 64'(addr_err), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_post_do_en", 64'(do_en), 64'd0);
    send_frame(12, 10, 1'b1);
    idle_in();
    wait_drain("t6_drain", 100);
    chk("t6_run", 64'(last_run), 64'd12);
    chk("t6_overflow", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
